// File: rtl/ui_cmd_parse_mc_if.sv
// Bus between the UART command parser and its neighbours: the character
// source and echo FIFO, the response generator, the particle sink, the
// memory channels and the go register.
interface ui_cmd_parse_mc_if #(
  parameter int PSIZE     = 52,
  parameter int ADDRWIDTH = 12,
  parameter int DWIDTH    = 16,
  parameter int NUM_CH    = 4
);
  logic [7:0]           rx_data;
  logic                 rx_data_rdy;
  logic                 char_fifo_full;
  logic                 send_resp_val;
  logic [1:0]           send_resp_type;
  logic                 send_resp_done;
  logic                 ui_particle_wr;
  logic [PSIZE-1:0]     ui_particle_data;
  logic                 ui_particle_rdy;
  logic [NUM_CH-1:0]    ui_wr;
  logic [NUM_CH-1:0]    ui_rd;
  logic [ADDRWIDTH-1:0] ui_addr;
  logic [DWIDTH-1:0]    ui_wdata;
  logic                 ui_go_wr;
  logic [31:0]          ui_go_data;
  logic [7:0]           err_count;

  // Parser side
  modport master (
    input  rx_data, rx_data_rdy, char_fifo_full, send_resp_done, ui_particle_rdy,
    output send_resp_val, send_resp_type, ui_particle_wr, ui_particle_data,
           ui_wr, ui_rd, ui_addr, ui_wdata, ui_go_wr, ui_go_data, err_count
  );

  // Environment side
  modport slave (
    output rx_data, rx_data_rdy, char_fifo_full, send_resp_done, ui_particle_rdy,
    input  send_resp_val, send_resp_type, ui_particle_wr, ui_particle_data,
           ui_wr, ui_rd, ui_addr, ui_wdata, ui_go_wr, ui_go_data, err_count
  );
endinterface

// File: rtl/ui_cmd_parse_mc.sv
// Multi-channel UART command parser: "*<cmd><hex args>" frames become
// particle pushes, channel-indexed memory writes/reads and go commands,
// with ESC abort, '*' resync, inter-character timeout and an error counter.
module ui_cmd_parse_mc #(
  parameter int          PSIZE       = 52,
  parameter int          ADDRWIDTH   = 12,
  parameter int          DWIDTH      = 16,
  parameter int          NUM_CH      = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  ui_cmd_parse_mc_if.master bus
);

  localparam int AC    = (ADDRWIDTH + 3) / 4;
  localparam int DC    = (DWIDTH + 3) / 4;
  localparam int PC    = (PSIZE + 3) / 4;
  localparam int WC    = 1 + AC + DC;
  localparam int RC    = 1 + AC;
  localparam int GC    = 8;
  localparam int M1    = (PC > WC) ? PC : WC;
  localparam int ARGCH = (M1 > GC) ? M1 : GC;
  localparam int ARGW  = 4 * ARGCH;
  localparam int CW    = $clog2(ARGCH + 1);

  localparam logic [6:0] CH_STAR = 7'h2A;
  localparam logic [6:0] CH_ESC  = 7'h1B;
  localparam logic [1:0] RESP_OK   = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;
  localparam logic [1:0] RESP_DATA = 2'b10;

  typedef enum logic [2:0] {IDLE, CMD_WAIT, GET_ARG, PUSH_WAIT, SEND_RESP} state_t;
  typedef enum logic [1:0] {CMD_P, CMD_W, CMD_R, CMD_G} cmd_t;

  state_t            state;
  cmd_t              cmd;
  logic              rdy_q;
  logic              new_char;
  logic [6:0]        c;
  logic [6:0]        lc;
  logic              is_hex;
  logic [3:0]        nib;
  logic [ARGW-5:0]   arg;
  logic [ARGW-1:0]   next_arg;
  logic [CW-1:0]     arg_cnt;
  logic [31:0]       tcnt;
  logic              timeout_hit;
  logic [3:0]        ch_sel;
  logic              ch_bad;
  logic [NUM_CH-1:0] ch_hot;
  logic [7:0]        err_inc;
  logic              unused_rx_msb;

  assign unused_rx_msb = bus.rx_data[7];

  // Edge detect on rx_data_rdy so a held strobe yields one character
  always_ff @(posedge clk) begin
    rdy_q <= bus.rx_data_rdy;
  end

  // Character decode, argument assembly with the incoming nibble, channel and timeout checks
  always_comb begin
    c        = bus.rx_data[6:0];
    lc       = c | 7'h20;
    new_char = bus.rx_data_rdy & ~rdy_q & ~bus.char_fifo_full;
    is_hex   = 1'b0;
    nib      = '0;
    if (c >= 7'h30 && c <= 7'h39) begin
      is_hex = 1'b1;
      nib    = c[3:0];
    end else if (lc >= 7'h61 && lc <= 7'h66) begin
      is_hex = 1'b1;
      nib    = lc[3:0] + 4'd9;
    end
    next_arg    = {arg, nib};
    ch_sel      = (cmd == CMD_W) ? next_arg[4*(AC+DC) +: 4] : next_arg[4*AC +: 4];
    ch_bad      = ({1'b0, ch_sel} >= 5'(NUM_CH));
    ch_hot      = NUM_CH'(1) << ch_sel;
    timeout_hit = (TIMEOUT_CYC != 0) && !new_char && (tcnt == 32'(TIMEOUT_CYC - 1));
    err_inc     = (bus.err_count == 8'hFF) ? 8'hFF : bus.err_count + 8'd1;
  end

  // Parser FSM with registered strobes, response request and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      cmd                  <= CMD_P;
      arg                  <= '0;
      arg_cnt              <= '0;
      tcnt                 <= '0;
      bus.send_resp_val    <= 1'b0;
      bus.send_resp_type   <= RESP_ERR;
      bus.ui_particle_wr   <= 1'b0;
      bus.ui_particle_data <= '0;
      bus.ui_wr            <= '0;
      bus.ui_rd            <= '0;
      bus.ui_addr          <= '0;
      bus.ui_wdata         <= '0;
      bus.ui_go_wr         <= 1'b0;
      bus.ui_go_data       <= '0;
      bus.err_count        <= '0;
    end else begin
      bus.send_resp_val <= 1'b0;
      bus.ui_wr         <= '0;
      bus.ui_rd         <= '0;
      bus.ui_go_wr      <= 1'b0;
      // Every state entry outside the timed states happens on a new_char or
      // passes through IDLE/SEND_RESP, so these two clears cover "clear on entry".
      tcnt <= (new_char || state == IDLE || state == SEND_RESP) ? '0 : tcnt + 32'd1;

      case (state)
        IDLE: begin
          if (new_char && c == CH_STAR) state <= CMD_WAIT;
        end

        CMD_WAIT: begin
          if (timeout_hit) begin
            bus.send_resp_val  <= 1'b1;
            bus.send_resp_type <= RESP_ERR;
            bus.err_count      <= err_inc;
            state              <= SEND_RESP;
          end else if (new_char) begin
            arg <= '0;
            if (c == CH_ESC) begin
              state <= IDLE;
            end else if (c == CH_STAR) begin
              state <= CMD_WAIT;
            end else if (lc == 7'h70) begin
              cmd <= CMD_P; arg_cnt <= CW'(PC); state <= GET_ARG;
            end else if (lc == 7'h77) begin
              cmd <= CMD_W; arg_cnt <= CW'(WC); state <= GET_ARG;
            end else if (lc == 7'h72) begin
              cmd <= CMD_R; arg_cnt <= CW'(RC); state <= GET_ARG;
            end else if (lc == 7'h67) begin
              cmd <= CMD_G; arg_cnt <= CW'(GC); state <= GET_ARG;
            end else begin
              bus.send_resp_val  <= 1'b1;
              bus.send_resp_type <= RESP_ERR;
              bus.err_count      <= err_inc;
              state              <= SEND_RESP;
            end
          end
        end

        GET_ARG: begin
          if (timeout_hit) begin
            bus.send_resp_val  <= 1'b1;
            bus.send_resp_type <= RESP_ERR;
            bus.err_count      <= err_inc;
            state              <= SEND_RESP;
          end else if (new_char) begin
            if (c == CH_ESC) begin
              state <= IDLE;
            end else if (c == CH_STAR) begin
              state <= CMD_WAIT;
            end else if (!is_hex) begin
              bus.send_resp_val  <= 1'b1;
              bus.send_resp_type <= RESP_ERR;
              bus.err_count      <= err_inc;
              state              <= SEND_RESP;
            end else if (arg_cnt != CW'(1)) begin
              arg     <= next_arg[ARGW-5:0];
              arg_cnt <= arg_cnt - CW'(1);
            end else begin
              case (cmd)
                CMD_P: begin
                  bus.ui_particle_wr   <= 1'b1;
                  bus.ui_particle_data <= next_arg[PSIZE-1:0];
                  state                <= PUSH_WAIT;
                end
                CMD_W, CMD_R: begin
                  bus.send_resp_val <= 1'b1;
                  state             <= SEND_RESP;
                  if (ch_bad) begin
                    bus.send_resp_type <= RESP_ERR;
                    bus.err_count      <= err_inc;
                  end else if (cmd == CMD_W) begin
                    bus.ui_wr          <= ch_hot;
                    bus.ui_addr        <= next_arg[4*DC +: ADDRWIDTH];
                    bus.ui_wdata       <= next_arg[DWIDTH-1:0];
                    bus.send_resp_type <= RESP_OK;
                  end else begin
                    bus.ui_rd          <= ch_hot;
                    bus.ui_addr        <= next_arg[ADDRWIDTH-1:0];
                    bus.send_resp_type <= RESP_DATA;
                  end
                end
                default: begin
                  bus.ui_go_wr       <= 1'b1;
                  bus.ui_go_data     <= next_arg[31:0];
                  bus.send_resp_val  <= 1'b1;
                  bus.send_resp_type <= RESP_OK;
                  state              <= SEND_RESP;
                end
              endcase
            end
          end
        end

        PUSH_WAIT: begin
          // A transfer on the timeout cycle takes priority over the abort
          if (bus.ui_particle_rdy) begin
            bus.ui_particle_wr <= 1'b0;
            bus.send_resp_val  <= 1'b1;
            bus.send_resp_type <= RESP_OK;
            state              <= SEND_RESP;
          end else if (timeout_hit) begin
            bus.ui_particle_wr <= 1'b0;
            bus.send_resp_val  <= 1'b1;
            bus.send_resp_type <= RESP_ERR;
            bus.err_count      <= err_inc;
            state              <= SEND_RESP;
          end
        end

        SEND_RESP: begin
          if (bus.send_resp_done) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ui_cmd_parse_mc.sv
// Directed self-checking bench for ui_cmd_parse_mc (TIMEOUT_CYC = 100).
module tb_ui_cmd_parse_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ui_cmd_parse_mc_if #(.PSIZE(52), .ADDRWIDTH(12), .DWIDTH(16), .NUM_CH(4)) bus ();

  ui_cmd_parse_mc #(
    .PSIZE(52), .ADDRWIDTH(12), .DWIDTH(16), .NUM_CH(4), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int cyc    = 0;
  int last_edge = 0;

  int          wr_cnt = 0, rd_cnt = 0, go_cnt = 0, resp_cnt = 0;
  logic [3:0]  last_wr, last_rd;
  logic [11:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [31:0] go_data;
  logic [1:0]  resp_type;
  int          wr_cyc, rd_cyc, resp_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe and response seen on the bus
  always @(negedge clk) begin
    if (|bus.ui_wr) begin
      wr_cnt++; last_wr = bus.ui_wr; wr_addr = bus.ui_addr; wr_data = bus.ui_wdata; wr_cyc = cyc;
    end
    if (|bus.ui_rd) begin
      rd_cnt++; last_rd = bus.ui_rd; rd_addr = bus.ui_addr; rd_cyc = cyc;
    end
    if (bus.ui_go_wr) begin
      go_cnt++; go_data = bus.ui_go_data;
    end
    if (bus.send_resp_val) begin
      resp_cnt++; resp_type = bus.send_resp_type; resp_cyc = cyc;
    end
  end

  // Response generator model: finish one cycle after each request
  initial begin
    bus.send_resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.send_resp_val) begin
        @(posedge clk); #1 bus.send_resp_done = 1'b1;
        @(posedge clk); #1 bus.send_resp_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] ch, input int hold = 1);
    @(posedge clk); #1;
    bus.rx_data = ch;
    bus.rx_data_rdy = 1'b1;
    @(posedge clk); #1;
    last_edge = cyc;
    repeat (hold - 1) @(posedge clk);
    #1 bus.rx_data_rdy = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic wait_resp(input string tag, input int n0, input int max_cyc);
    int k = 0;
    while (resp_cnt == n0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(resp_cnt - n0), 64'd1);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int n0, w0, g0, e;
    int hold;
    bus.rx_data = 8'h00;
    bus.rx_data_rdy = 1'b0;
    bus.char_fifo_full = 1'b0;
    bus.ui_particle_rdy = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_val",  64'(bus.send_resp_val), 64'd0);
    chk("rst_type", 64'(bus.send_resp_type), 64'd1);
    chk("rst_pwr",  64'(bus.ui_particle_wr), 64'd0);
    chk("rst_wr",   64'(bus.ui_wr), 64'd0);
    chk("rst_go",   64'(bus.ui_go_wr), 64'd0);
    chk("rst_err",  64'(bus.err_count), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Write to channel 2
    n0 = resp_cnt;
    send_str("*W2123ABCD");
    wait_resp("w_resp", n0, 20);
    chk("w_cnt",   64'(wr_cnt), 64'd1);
    chk("w_hot",   64'(last_wr), 64'b0100);
    chk("w_addr",  64'(wr_addr), 64'h123);
    chk("w_data",  64'(wr_data), 64'hABCD);
    chk("w_lat",   64'(wr_cyc - last_edge), 64'd0);
    chk("w_type",  64'(resp_type), 64'd0);

    // Read from channel 0, lowercase
    n0 = resp_cnt;
    send_str("*r0fff");
    wait_resp("r_resp", n0, 20);
    chk("r_cnt",  64'(rd_cnt), 64'd1);
    chk("r_hot",  64'(last_rd), 64'b0001);
    chk("r_addr", 64'(rd_addr), 64'hFFF);
    chk("r_lat",  64'(rd_cyc - last_edge), 64'd0);
    chk("r_type", 64'(resp_type), 64'd2);

    // Channel out of range
    n0 = resp_cnt;
    send_str("*W50000000");
    wait_resp("ch_resp", n0, 20);
    chk("ch_nowr", 64'(wr_cnt), 64'd1);
    chk("ch_type", 64'(resp_type), 64'd1);
    chk("ch_err",  64'(bus.err_count), 64'd1);

    // Particle back-pressure for 20 cycles
    bus.ui_particle_rdy = 1'b0;
    n0 = resp_cnt;
    send_str("*P1111111111111");
    hold = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ui_particle_wr && bus.ui_particle_data == 52'h1111111111111) hold++;
    end
    chk("p_hold",   64'(hold), 64'd20);
    chk("p_noresp", 64'(resp_cnt - n0), 64'd0);
    bus.ui_particle_rdy = 1'b1;
    @(negedge clk);
    chk("p_wr_off", 64'(bus.ui_particle_wr), 64'd0);
    chk("p_val",    64'(bus.send_resp_val), 64'd1);
    chk("p_type",   64'(bus.send_resp_type), 64'd0);
    repeat (4) @(posedge clk);

    // Inter-character timeout
    n0 = resp_cnt; g0 = go_cnt;
    send_str("*G12");
    e = last_edge;
    wait_resp("to_resp", n0, 200);
    chk("to_lat",  64'(resp_cyc - e), 64'd100);
    chk("to_type", 64'(resp_type), 64'd1);
    chk("to_nogo", 64'(go_cnt - g0), 64'd0);
    chk("to_err",  64'(bus.err_count), 64'd2);

    // ESC abort then a full go command
    n0 = resp_cnt; g0 = go_cnt;
    send_str("*G12");
    send_char(8'h1B);
    send_str("*G0000000A");
    wait_resp("esc_resp", n0, 20);
    chk("esc_go",    64'(go_cnt - g0), 64'd1);
    chk("esc_data",  64'(go_data), 64'h0000000A);
    chk("esc_type",  64'(resp_type), 64'd0);
    chk("esc_nresp", 64'(resp_cnt - n0), 64'd1);

    // Held rx_data_rdy counts once
    n0 = resp_cnt; g0 = go_cnt;
    send_str("*G");
    send_char("0", 6);
    send_str("000001F");
    wait_resp("hold_resp", n0, 20);
    chk("hold_go",   64'(go_cnt - g0), 64'd1);
    chk("hold_data", 64'(go_data), 64'h0000001F);

    // Characters dropped while the echo FIFO is full
    n0 = resp_cnt; g0 = go_cnt;
    send_str("*G");
    bus.char_fifo_full = 1'b1;
    send_str("55");
    bus.char_fifo_full = 1'b0;
    send_str("0000002B");
    wait_resp("full_resp", n0, 20);
    chk("full_go",   64'(go_cnt - g0), 64'd1);
    chk("full_data", 64'(go_data), 64'h0000002B);

    // '*' mid-arguments restarts the frame
    n0 = resp_cnt; g0 = go_cnt; w0 = wr_cnt;
    send_str("*W21*G00000003");
    wait_resp("star_resp", n0, 20);
    chk("star_go",    64'(go_cnt - g0), 64'd1);
    chk("star_data",  64'(go_data), 64'h00000003);
    chk("star_nowr",  64'(wr_cnt - w0), 64'd0);
    chk("star_nresp", 64'(resp_cnt - n0), 64'd1);
    chk("star_err",   64'(bus.err_count), 64'd2);

    // Reset while a particle push is pending
    bus.ui_particle_rdy = 1'b0;
    send_str("*PAAAAAAAAAAAAA");
    @(negedge clk);
    chk("rp_pwr",  64'(bus.ui_particle_wr), 64'd1);
    chk("rp_data", 64'(bus.ui_particle_data), 64'hAAAAAAAAAAAAA);
    n0 = resp_cnt;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rp_pwr0", 64'(bus.ui_particle_wr), 64'd0);
    chk("rp_err0", 64'(bus.err_count), 64'd0);
    chk("rp_type", 64'(bus.send_resp_type), 64'd1);
    bus.ui_particle_rdy = 1'b1;
    repeat (150) @(negedge clk);
    chk("rp_silent", 64'(resp_cnt - n0), 64'd0);
    n0 = resp_cnt;
    send_str("*G00000007");
    wait_resp("rp_go_resp", n0, 20);
    chk("rp_go_data", 64'(go_data), 64'h00000007);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
